// File: rtl/dmem_dump_pkg.sv
// Shared types and constants for the data-memory dump controller.
// Imported by the controller top and its helpers.
package dmem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry synchronous FIFO buffering words returned by the data memory.
// Head word is visible combinationally on rdata_o.
module dump_fifo2 #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory dump controller: passes datapath accesses through while idle,
// then streams NUM_WORDS words from BASE_ADDR upward to the file sink.
module dmem_dump_ctrl
  import dmem_dump_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                NUM_WORDS = 256,
  parameter int                RD_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic              dut_rd,
  input  logic              dut_wr,
  input  logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_wdata,
  output logic              mem_rd,
  output logic              mem_wr_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              snk_ready,
  output logic              snk_en,
  output logic [DATA_W-1:0] snk_data,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [1:0]        outst;
  logic [1:0]        occ;
  logic              can_issue;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign next_addr = BASE_ADDR
                   + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);

  if (RD_LAT == 1) begin : g_lat1
    assign vld_d = issue;
  end else begin : g_latn
    assign vld_d = {vld_q[RD_LAT-2:0], issue};
  end

  assign push = vld_q[RD_LAT-1];

  always_comb begin
    outst = 2'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      outst = outst + {1'b0, vld_q[i]};
    end
  end

  assign occ    = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
  assign pop    = !fifo_empty && snk_ready;
  assign snk_en = pop;

  // A word leaving the FIFO this cycle frees a credit, which keeps
  // the stream at one word per cycle when the sink never stalls.
  assign can_issue = ({1'b0, outst} + {1'b0, occ})
                   < (3'd2 + {2'b0, pop});

  dump_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .push_i (push),
    .wdata_i(mem_rdata),
    .pop_i  (pop),
    .rdata_o(snk_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    issue     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr_n  = 1'b1;
    mem_addr  = addr_q;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        mem_rd    = dut_rd;
        mem_wr_n  = ~dut_wr;
        mem_addr  = dut_addr;
        mem_wdata = dut_wdata;
        if (start) state_d = QUIESCE;
      end
      QUIESCE: begin
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (can_issue) begin
          issue    = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = next_addr;
          addr_d   = next_addr;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the final word is popped so done follows it directly.
        if (outst == 2'd0
            && (fifo_empty || (!fifo_full && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) state_d = QUIESCE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == QUIESCE)
             || (state_q == READ)
             || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule
